load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface: accepts one load/store request at a time from the execute stage and issues it to data_memory using the wr_en/rw_mode/addr/w_data/r_data protocol.
- Checks alignment, sequences the access through a small FSM and sign/zero-extends load data.
- Returns a single-cycle response to the pipeline.

Parameters:
DMEM_DATA_WIDTH, 32, data width of memory and CPU data paths
DMEM_ADDR_WIDTH, 4, byte-address width into data_memory
DMEM_RD_LATENCY, 1, cycles from address presented to valid mem_r_data; legal values 0 or 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_store  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  DMEM_ADDR_WIDTH  byte address
req_wdata  input  DMEM_DATA_WIDTH  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DMEM_DATA_WIDTH  extended load data; 0 for stores or faults
resp_fault  output  1  misaligned or illegal-size request; qualified by resp_valid
mem_wr_en  output  1  to data_memory wr_en
mem_rw_mode  output  2  to data_memory rw_mode: 00 word, 01 halfword, 10 byte, 11 none
mem_addr  output  DMEM_ADDR_WIDTH  to data_memory addr
mem_w_data  output  DMEM_DATA_WIDTH  to data_memory w_data
mem_r_data  input  DMEM_DATA_WIDTH  from data_memory r_data; loaded value right-aligned, upper bits zero

Behaviour:
- Interface clocking: one clock, clk. rst is synchronous and active-high.
- Handshake:
  - Request is accepted on the clock edge where req_valid & req_ready.
  - All request fields are latched at acceptance.
  - req_ready = 1 only in IDLE.
- FSM states and transitions:
  - IDLE -> FAULT if the accepted request is misaligned or illegal:
    - halfword with addr[0]=1,
    - word with addr[1:0]!=0,
    - req_size=11.
  - IDLE -> ACCESS otherwise.
  - ACCESS drives mem_addr, mem_rw_mode (mapped from size), mem_w_data and mem_wr_en=req_store for exactly one cycle.
  - ACCESS, store -> RESP.
  - ACCESS, load, LAT=0: mem_r_data is sampled in ACCESS -> RESP.
  - ACCESS, load, LAT=1 -> WAIT. WAIT holds the memory outputs with mem_wr_en=0, samples mem_r_data -> RESP.
  - FAULT -> RESP with fault flag set. No memory access occurs: mem_wr_en stays 0 and mem_rw_mode stays 11.
  - RESP: resp_valid=1 for one cycle -> IDLE. Back-to-back requests are therefore accepted no faster than every 3 (+LAT for loads) cycles.
- Latency, with acceptance at cycle 0:
  - aligned store: mem_wr_en in cycle 1, resp_valid in cycle 2;
  - load: resp_valid in cycle 2+DMEM_RD_LATENCY;
  - fault: resp_valid in cycle 2.
- Idle bus values: mem_wr_en=0, mem_rw_mode=11, mem_addr and mem_w_data hold their last values.
- Load extension:
  - byte: bit 7 replicated (signed) or zeros (unsigned) into bits [DMEM_DATA_WIDTH-1:8];
  - halfword: same rule from bit 15;
  - word: passed unchanged.
- Store data: only the low 8/16/32 bits are meaningful to memory. The unit drives req_wdata unmodified.
- Reset values:
  - state IDLE, resp_valid 0, resp_rdata 0, resp_fault 0;
  - mem_wr_en 0, mem_rw_mode 11, mem_addr 0, mem_w_data 0;
  - req_ready 1 once reset deasserts.
- Reset mid-operation: FSM returns to IDLE on that edge. mem_wr_en drops, no response is produced and the in-flight request is discarded.
- req_valid while not ready: ignored; the requester must hold it.
- Address wrap: mem_addr is passed through unchanged. The memory decodes any range errors.

Optional Feature:
- Macro: LSU_ACCESS_COUNTERS_EN.
- When defined, three extra outputs are added, each 32 bits:
  - load_count: +1 per completed non-faulting load, in its RESP cycle;
  - store_count: +1 per completed non-faulting store;
  - fault_count: +1 per faulting response.
- The counters reset to 0 on rst and wrap modulo 2^32.
- When not defined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with all inputs 0 -> req_ready=1, mem_rw_mode=11, mem_wr_en=0, resp_valid=0.
- Store byte, addr 5, wdata 0x0F -> cycle 1: mem_wr_en=1, mem_rw_mode=10, mem_addr=5, mem_w_data=0x0F; cycle 2: resp_valid=1, resp_fault=0.
- Store halfword, addr 7 -> resp_valid in cycle 2 with resp_fault=1; mem_wr_en never asserts; same check for word at addr 6 and for req_size=11.
- Load byte signed, addr 5, LAT=1, memory returns 0x000000F0 -> resp_valid in cycle 3 with resp_rdata=0xFFFFFFF0. Unsigned load returns 0x000000F0.
- Load halfword signed, addr 6, memory returns 0x00008012 -> resp_rdata=0xFFFF8012. Word load, addr 8, memory returns 0x211E1B18 -> resp_rdata=0x211E1B18.
- Assert rst during ACCESS of a store -> mem_wr_en=0 the next cycle, no resp_valid, req_ready=1 after reset. With LSU_ACCESS_COUNTERS_EN, all counts read 0.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Data-memory initiator. Accepts one load/store at a time, checks
//            alignment, drives data_memory and returns a one-cycle response.
//            Optional LSU_ACCESS_COUNTERS_EN adds load/store/fault counters.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DMEM_DATA_WIDTH = 32,
    parameter int DMEM_ADDR_WIDTH = 4,
    parameter int DMEM_RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_store,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
    output logic                       resp_valid,
    output logic [DMEM_DATA_WIDTH-1:0] resp_rdata,
    output logic                       resp_fault,
    output logic                       mem_wr_en,
    output logic [1:0]                 mem_rw_mode,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DMEM_DATA_WIDTH-1:0] mem_w_data,
    input  logic [DMEM_DATA_WIDTH-1:0] mem_r_data
`ifdef LSU_ACCESS_COUNTERS_EN
    ,
    output logic [31:0]                load_count,
    output logic [31:0]                store_count,
    output logic [31:0]                fault_count
`endif
);

    localparam logic [1:0] c_RW_WORD = 2'b00;
    localparam logic [1:0] c_RW_HALF = 2'b01;
    localparam logic [1:0] c_RW_BYTE = 2'b10;
    localparam logic [1:0] c_RW_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_FAULT  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                     state_q,       state_d;
    logic                       store_q,       store_d;
    logic [1:0]                 size_q,        size_d;
    logic                       uns_q,         uns_d;
    logic                       resp_valid_q,  resp_valid_d;
    logic [DMEM_DATA_WIDTH-1:0] resp_rdata_q,  resp_rdata_d;
    logic                       resp_fault_q,  resp_fault_d;
    logic                       mem_wr_en_q,   mem_wr_en_d;
    logic [1:0]                 mem_rw_mode_q, mem_rw_mode_d;
    logic [DMEM_ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
    logic [DMEM_DATA_WIDTH-1:0] mem_w_data_q,  mem_w_data_d;

    logic                       w_misaligned;
    logic [1:0]                 w_rw_mode;
    logic [DMEM_DATA_WIDTH-1:0] w_load_ext;

    always_comb begin
        w_misaligned = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        case (req_size)
            2'b00:   w_rw_mode = c_RW_BYTE;
            2'b01:   w_rw_mode = c_RW_HALF;
            2'b10:   w_rw_mode = c_RW_WORD;
            default: w_rw_mode = c_RW_NONE;
        endcase
    end

    // Memory returns the loaded value right-aligned; only extension is needed.
    always_comb begin
        case (size_q)
            2'b00:   w_load_ext = {{(DMEM_DATA_WIDTH-8){~uns_q & mem_r_data[7]}},
                                   mem_r_data[7:0]};
            2'b01:   w_load_ext = {{(DMEM_DATA_WIDTH-16){~uns_q & mem_r_data[15]}},
                                   mem_r_data[15:0]};
            default: w_load_ext = mem_r_data;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        size_d        = size_q;
        uns_d         = uns_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_fault_d  = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_rw_mode_d = mem_rw_mode_q;
        mem_addr_d    = mem_addr_q;
        mem_w_data_d  = mem_w_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (w_misaligned) begin
                        state_d = S_FAULT;
                    end else begin
                        // Bus is loaded on the accept edge so the access is visible next cycle.
                        state_d       = S_ACCESS;
                        mem_addr_d    = req_addr;
                        mem_w_data_d  = req_wdata;
                        mem_rw_mode_d = w_rw_mode;
                        mem_wr_en_d   = req_store;
                    end
                end
            end
            S_ACCESS: begin
                if (store_q || (DMEM_RD_LATENCY == 0)) begin
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_rdata_d  = store_q ? '0 : w_load_ext;
                    mem_rw_mode_d = c_RW_NONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d       = S_RESP;
                resp_valid_d  = 1'b1;
                resp_rdata_d  = w_load_ext;
                mem_rw_mode_d = c_RW_NONE;
            end
            S_FAULT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d       = S_IDLE;
                mem_rw_mode_d = c_RW_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            store_q       <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_fault_q  <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rw_mode_q <= c_RW_NONE;
            mem_addr_q    <= '0;
            mem_w_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_fault_q  <= resp_fault_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rw_mode_q <= mem_rw_mode_d;
            mem_addr_q    <= mem_addr_d;
            mem_w_data_q  <= mem_w_data_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_fault  = resp_fault_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_rw_mode = mem_rw_mode_q;
    assign mem_addr    = mem_addr_q;
    assign mem_w_data  = mem_w_data_q;

`ifdef LSU_ACCESS_COUNTERS_EN
    logic [31:0] load_count_q,  load_count_d;
    logic [31:0] store_count_q, store_count_d;
    logic [31:0] fault_count_q, fault_count_d;

    // resp_fault_q is only ever set during RESP, so it classifies the response.
    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        fault_count_d = fault_count_q;
        if (state_q == S_RESP) begin
            if (resp_fault_q)
                fault_count_d = fault_count_q + 32'd1;
            else if (store_q)
                store_count_d = store_count_q + 32'd1;
            else
                load_count_d  = load_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_count_q  <= 32'd0;
            store_count_q <= 32'd0;
            fault_count_q <= 32'd0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign load_count  = load_count_q;
    assign store_count = store_count_q;
    assign fault_count = fault_count_q;
`endif

endmodule
`default_nettype wire
